tpiu_from_axi: RTL and testbench

Transmit-side counterpart of the TPIU-to-AXI-stream bridge. It accepts 32-bit trace words on an AXI4-Stream slave port, buffers them in a small FIFO, and drives a continuous 32-bit TPIU-formatted word stream. Idle cycles are filled with half-synch packets, and full synch packets are inserted after reset and periodically. It sits at the trace-output end of the debug fabric, so that a downstream TPIU receiver can strip the synchronisation words and recover the payload.

---
 rtl/tpiu_from_axi.sv | 162 ++++++++++++++++
 tb/tb_tpiu_from_axi.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpiu_from_axi.sv
// rtl/tpiu_from_axi.sv - AXI-Stream trace words to continuous TPIU word stream with synch insertion
module tpiu_from_axi #(
    parameter int FIFO_DEPTH       = 8,
    parameter int SYNC_PERIOD      = 256,
    parameter int RESET_SYNC_WORDS = 4
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [31:0]                   TDATA,
    input  logic                          TVALID,
    input  logic                          TLAST,
    output logic                          TREADY,
    output logic [31:0]                   OUT_DATA,
    output logic                          OUT_LAST,
    output logic                          OUT_SYNC,
    output logic                          ILLEGAL,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);

    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;
    localparam int PCW = $clog2(SYNC_PERIOD);
    localparam int RCW = $clog2(RESET_SYNC_WORDS + 1);

    localparam logic [31:0] SYNCH = 32'h7FFF_FFFF;
    localparam logic [31:0] HALF  = 32'h7FFF_7FFF;

    typedef enum logic [1:0] {
        ST_RST_SYNC = 2'd0,
        ST_RUN      = 2'd1,
        ST_PER_SYNC = 2'd2
    } state_t;

    state_t          state_q;
    logic [RCW-1:0]  rst_cnt_q;
    logic [PCW-1:0]  per_cnt_q;
    logic [31:0]     out_data_q;
    logic            out_last_q;
    logic            out_sync_q;

    logic [32:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic            tready_q;
    logic            illegal_q;

    logic            beat;
    logic            pattern_hit;
    logic            push;
    logic            pop;
    logic [32:0]     head;

    // A beat is always consumed when accepted; words that look like synch
    // patterns are dropped so the receiver can never mistake them for framing.
    assign beat        = TVALID && tready_q;
    assign pattern_hit = (TDATA == SYNCH) || (TDATA == HALF);
    assign push        = beat && !pattern_hit;
    assign pop         = (state_q == ST_RUN) && (level_q != '0);
    assign head        = mem_q[rd_ptr_q];

    // Occupancy after this edge; also drives the registered ready.
    always_comb begin
        level_d = level_q + LW'(push) - LW'(pop);
    end

    // Payload storage; a pushed word always goes through memory, never bypassed.
    always_ff @(posedge ACLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {TLAST, TDATA};
        end
    end

    // FIFO pointers, occupancy, ready and the sticky illegal-payload flag.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            tready_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q  <= level_d;
            tready_q <= (level_d < LW'(FIFO_DEPTH));
            if (beat && pattern_hit) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Output sequencer: reset synch burst, payload/half-synch, periodic synch.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q    <= ST_RST_SYNC;
            rst_cnt_q  <= '0;
            per_cnt_q  <= '0;
            out_data_q <= SYNCH;
            out_last_q <= 1'b0;
            out_sync_q <= 1'b1;
        end else begin
            case (state_q)
                ST_RST_SYNC: begin
                    out_data_q <= SYNCH;
                    out_last_q <= 1'b0;
                    out_sync_q <= 1'b1;
                    if (rst_cnt_q == RCW'(RESET_SYNC_WORDS - 1)) begin
                        rst_cnt_q <= '0;
                        state_q   <= ST_RUN;
                    end else begin
                        rst_cnt_q <= rst_cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    out_sync_q <= 1'b0;
                    if (pop) begin
                        out_data_q <= head[31:0];
                        out_last_q <= head[32];
                    end else begin
                        out_data_q <= HALF;
                        out_last_q <= 1'b0;
                    end
                    if (per_cnt_q == PCW'(SYNC_PERIOD - 1)) begin
                        per_cnt_q <= '0;
                        state_q   <= ST_PER_SYNC;
                    end else begin
                        per_cnt_q <= per_cnt_q + 1'b1;
                    end
                end
                ST_PER_SYNC: begin
                    out_data_q <= SYNCH;
                    out_last_q <= 1'b0;
                    out_sync_q <= 1'b1;
                    per_cnt_q  <= '0;
                    state_q    <= ST_RUN;
                end
                default: begin
                    state_q    <= ST_RST_SYNC;
                    rst_cnt_q  <= '0;
                    per_cnt_q  <= '0;
                    out_data_q <= SYNCH;
                    out_last_q <= 1'b0;
                    out_sync_q <= 1'b1;
                end
            endcase
        end
    end

    assign TREADY     = tready_q;
    assign OUT_DATA   = out_data_q;
    assign OUT_LAST   = out_last_q;
    assign OUT_SYNC   = out_sync_q;
    assign ILLEGAL    = illegal_q;
    assign FIFO_LEVEL = level_q;

endmodule

// File: tb/tb_tpiu_from_axi.sv
// tb/tb_tpiu_from_axi.sv - scoreboard bench for tpiu_from_axi
module tb_tpiu_from_axi;

    localparam int DEPTH = 8;
    localparam int SP    = 4;
    localparam int RSW   = 6;
    localparam logic [31:0] SYNCH = 32'h7FFF_FFFF;
    localparam logic [31:0] HALF  = 32'h7FFF_7FFF;

    logic        ACLK   = 1'b0;
    logic        ARESET = 1'b0;
    logic [31:0] TDATA  = '0;
    logic        TVALID = 1'b0;
    logic        TLAST  = 1'b0;
    logic        TREADY;
    logic [31:0] OUT_DATA;
    logic        OUT_LAST;
    logic        OUT_SYNC;
    logic        ILLEGAL;
    logic [$clog2(DEPTH):0] FIFO_LEVEL;

    tpiu_from_axi #(
        .FIFO_DEPTH       (DEPTH),
        .SYNC_PERIOD      (SP),
        .RESET_SYNC_WORDS (RSW)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .TDATA      (TDATA),
        .TVALID     (TVALID),
        .TLAST      (TLAST),
        .TREADY     (TREADY),
        .OUT_DATA   (OUT_DATA),
        .OUT_LAST   (OUT_LAST),
        .OUT_SYNC   (OUT_SYNC),
        .ILLEGAL    (ILLEGAL),
        .FIFO_LEVEL (FIFO_LEVEL)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [31:0] data;
        logic        last;
        int          ed;
    } item_t;

    item_t exp_q[$];
    int    rd_idx  = 0;
    int    n_edge  = 0;
    int    checks  = 0;
    int    errors  = 0;
    int    popped  = 0;
    bit    m_illegal = 1'b0;
    bit    m_acc     = 1'b0;
    int    m_lvl;
    int    mon_lvl;
    item_t m_it;

    function automatic bit sync_edge(input int n);
        if (n <= RSW) return 1'b1;
        return ((n - RSW - 1) % (SP + 1)) == SP;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"},  OUT_DATA, SYNCH);
        chk({tag, "_sync"},  32'(OUT_SYNC), 32'd1);
        chk({tag, "_last"},  32'(OUT_LAST), 32'd0);
        chk({tag, "_ill"},   32'(ILLEGAL), 32'd0);
        chk({tag, "_level"}, 32'(FIFO_LEVEL), 32'd0);
        chk({tag, "_ready"}, 32'(TREADY), 32'd0);
    endtask

    // Reference model: accepts beats from the spec rules and queues expected words.
    initial forever begin
        @(posedge ACLK or posedge ARESET);
        if (ARESET) begin
            exp_q.delete();
            n_edge    = 0;
            m_illegal = 1'b0;
            m_acc     = 1'b0;
        end else begin
            m_lvl = exp_q.size() - rd_idx;
            m_acc = TVALID && (n_edge >= 1) && (m_lvl < DEPTH);
            n_edge++;
            if (m_acc) begin
                if (TDATA == SYNCH || TDATA == HALF) begin
                    m_illegal = 1'b1;
                end else begin
                    m_it.data = TDATA;
                    m_it.last = TLAST;
                    m_it.ed   = n_edge;
                    exp_q.push_back(m_it);
                end
            end
        end
    end

    // Monitor: compares every output word against the schedule and scoreboard.
    initial forever begin
        @(negedge ACLK);
        if (ARESET) begin
            rd_idx = 0;
        end else if (n_edge >= 1) begin
            if (sync_edge(n_edge)) begin
                chk("out_sync", 32'(OUT_SYNC), 32'd1);
                chk("out_data_synch", OUT_DATA, SYNCH);
                chk("out_last", 32'(OUT_LAST), 32'd0);
            end else begin
                chk("out_sync", 32'(OUT_SYNC), 32'd0);
                if (rd_idx < exp_q.size() && exp_q[rd_idx].ed < n_edge) begin
                    chk("out_data_payload", OUT_DATA, exp_q[rd_idx].data);
                    chk("out_last_payload", 32'(OUT_LAST), 32'(exp_q[rd_idx].last));
                    rd_idx++;
                    popped++;
                end else begin
                    chk("out_data_half", OUT_DATA, HALF);
                    chk("out_last", 32'(OUT_LAST), 32'd0);
                end
            end
            mon_lvl = exp_q.size() - rd_idx;
            chk("fifo_level", 32'(FIFO_LEVEL), 32'(mon_lvl));
            chk("tready", 32'(TREADY), 32'(mon_lvl < DEPTH));
            chk("illegal", 32'(ILLEGAL), 32'(m_illegal));
        end
    end

    task automatic send(input logic [31:0] d, input logic l);
        int waited = 0;
        bit acc    = 1'b0;
        @(negedge ACLK);
        TDATA  = d;
        TLAST  = l;
        TVALID = 1'b1;
        while (!acc && waited < 100) begin
            @(posedge ACLK);
            #1;
            acc = m_acc;
            waited++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got not-accepted expected accepted data %h", d);
        end
        TVALID = 1'b0;
    endtask

    task automatic idle(input int k);
        TVALID = 1'b0;
        repeat (k) @(negedge ACLK);
    endtask

    task automatic wait_drain();
        int w = 0;
        while (rd_idx < exp_q.size() && w < 300) begin
            @(negedge ACLK);
            w++;
        end
        @(negedge ACLK);
        #1;
        chk("drain_empty", 32'(exp_q.size() - rd_idx), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge ACLK);
        #2;
        TVALID = 1'b0;
        ARESET = 1'b1;
        #1;
        chk_reset_vals("rst");
        @(negedge ACLK);
        #1;
        ARESET = 1'b0;
    endtask

    initial begin
        int e;
        int p0;
        int max_lvl;
        #1 ARESET = 1'b1;
        #1 chk_reset_vals("por");
        @(negedge ACLK);
        @(negedge ACLK);
        #1 ARESET = 1'b0;

        // idle: reset synch burst, half-synch fill, periodic synch
        idle(40);

        // single word with TLAST
        send(32'h1234_5678, 1'b1);
        e = n_edge;
        @(negedge ACLK);
        @(negedge ACLK);
        if (sync_edge(e + 1)) @(negedge ACLK);
        #1;
        chk("single_data", OUT_DATA, 32'h1234_5678);
        chk("single_last", 32'(OUT_LAST), 32'd1);
        idle(10);

        // back-pressure: 1..20 starting during the reset synch burst
        do_reset();
        p0      = popped;
        max_lvl = 0;
        for (int i = 1; i <= 20; i++) begin
            send(32'(i), 1'b0);
            if (int'(FIFO_LEVEL) > max_lvl) max_lvl = int'(FIFO_LEVEL);
        end
        chk("bp_max_level", 32'(max_lvl), 32'd8);
        chk("bp_ready_low", 32'(TREADY), 32'd0);
        wait_drain();
        chk("bp_count", 32'(popped - p0), 32'd20);

        // illegal payload patterns
        idle(5);
        chk("illegal_clear", 32'(ILLEGAL), 32'd0);
        p0 = popped;
        send(32'd1, 1'b0);
        send(SYNCH, 1'b0);
        chk("illegal_set", 32'(ILLEGAL), 32'd1);
        send(32'd2, 1'b0);
        send(HALF, 1'b1);
        send(32'd3, 1'b1);
        wait_drain();
        chk("illegal_count", 32'(popped - p0), 32'd3);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            @(negedge ACLK);
            TVALID = ($urandom_range(0, 3) != 0);
            TLAST  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 19))
                0:       TDATA = SYNCH;
                1:       TDATA = HALF;
                default: TDATA = $urandom;
            endcase
        end
        idle(1);
        wait_drain();

        // asynchronous reset while holding 5 words mid-stream
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send(32'hA000_0000 + 32'(i), 1'b0);
        end
        chk("hold_level", 32'(FIFO_LEVEL), 32'd5);
        chk("hold_sync", 32'(OUT_SYNC), 32'd0);
        #2;
        ARESET = 1'b1;
        #1;
        chk_reset_vals("async");
        @(negedge ACLK);
        #1;
        ARESET = 1'b0;
        p0 = popped;
        idle(30);
        chk("async_no_old", 32'(popped - p0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
